// File: rtl/clock_pkg.sv
// Shared types and constants for the HH:MM:SS BCD time counter.
package clock_pkg;

  localparam int unsigned DIGIT_W               = 4;
  localparam int unsigned DEFAULT_TICKS_PER_SEC = 100_000_000;

  localparam logic [7:0]         MAX_HOUR    = 8'h23;
  localparam logic [7:0]         MAX_MIN     = 8'h59;
  localparam logic [DIGIT_W-1:0] MAX_UNITS   = 4'd9;
  localparam logic [DIGIT_W-1:0] MAX_TENS_MS = 4'd5;

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_CHECK    = 2'd1,
    ST_WAIT_LOW = 2'd2
  } clk_state_e;

  typedef struct packed {
    logic [DIGIT_W-1:0] tens;
    logic [DIGIT_W-1:0] units;
  } bcd_pair_t;

  // Both nibbles decimal and the pair no larger than max (pair compares as a BCD byte).
  function automatic logic bcd_pair_ok(input bcd_pair_t p, input logic [7:0] max);
    return (p.tens <= MAX_UNITS) && (p.units <= MAX_UNITS) && ({p.tens, p.units} <= max);
  endfunction

endpackage

// File: rtl/bcd_digit_counter.sv
// Single BCD digit counter wrapping at MAX, with clear/load priority over increment.
module bcd_digit_counter
  import clock_pkg::*;
#(
  parameter logic [DIGIT_W-1:0] MAX = MAX_UNITS
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               inc_i,
  input  logic               load_i,
  input  logic [DIGIT_W-1:0] load_val_i,
  input  logic               clr_i,
  output logic [DIGIT_W-1:0] digit_o,
  output logic               carry_out_c
);

  logic [DIGIT_W-1:0] digit_q;
  logic [DIGIT_W-1:0] digit_d;

  always_comb begin
    digit_d = digit_q;
    if (clr_i) begin
      digit_d = '0;
    end else if (load_i) begin
      digit_d = load_val_i;
    end else if (inc_i) begin
      digit_d = (digit_q == MAX) ? '0 : digit_q + DIGIT_W'(1);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      digit_q <= '0;
    end else begin
      digit_q <= digit_d;
    end
  end

  assign digit_o     = digit_q;
  assign carry_out_c = inc_i && !clr_i && !load_i && (digit_q == MAX);

endmodule

// File: rtl/clock_time_counter.sv
// Seconds-prescaled HH:MM:SS BCD time counter with a valid/ack time-set handshake.
module clock_time_counter
  import clock_pkg::*;
#(
  parameter int unsigned TICKS_PER_SEC = DEFAULT_TICKS_PER_SEC
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               run_en,
  input  logic               ny_eve,
  input  logic               set_valid,
  input  logic [7:0]         set_hh,
  input  logic [7:0]         set_mm,
  output logic               set_ack,
  output logic               set_err,
  output logic [DIGIT_W-1:0] hour_tens,
  output logic [DIGIT_W-1:0] hour_units,
  output logic [DIGIT_W-1:0] min_tens,
  output logic [DIGIT_W-1:0] min_units,
  output logic [DIGIT_W-1:0] sec_tens,
  output logic [DIGIT_W-1:0] sec_units,
  output logic               sec_tick,
  output logic               day_tick,
  output logic               ny_countdown
);

  localparam int unsigned        PRESC_W    = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
  localparam logic [PRESC_W-1:0] PRESC_TERM = PRESC_W'(TICKS_PER_SEC - 1);

  clk_state_e         state_q;
  clk_state_e         state_d;
  logic [PRESC_W-1:0] presc_q;
  logic [PRESC_W-1:0] presc_d;
  bcd_pair_t          hour_q;
  bcd_pair_t          hour_d;
  logic               set_ack_q;
  logic               set_err_q;
  logic               sec_tick_q;
  logic               day_tick_q;
  logic               ack_d;
  logic               err_d;

  logic               advance_c;
  logic               load_c;
  logic               term_c;
  logic               set_ok_c;
  logic               day_wrap_c;
  logic               sec_units_carry_c;
  logic               sec_tens_carry_c;
  logic               min_units_carry_c;
  logic               min_tens_carry_c;

  assign set_ok_c = bcd_pair_ok(bcd_pair_t'(set_hh), MAX_HOUR)
                 && bcd_pair_ok(bcd_pair_t'(set_mm), MAX_MIN);

  // FSM state register
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= ST_RUN;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_RUN:      if (set_valid)  state_d = ST_CHECK;
      ST_CHECK:                    state_d = ST_WAIT_LOW;
      ST_WAIT_LOW: if (!set_valid) state_d = ST_RUN;
      default:                     state_d = ST_RUN;
    endcase
  end

  // FSM outputs; a pending request in RUN freezes time so a set wins over a coincident tick
  always_comb begin
    advance_c = 1'b0;
    load_c    = 1'b0;
    ack_d     = 1'b0;
    err_d     = 1'b0;
    case (state_q)
      ST_RUN: advance_c = run_en && !set_valid;
      ST_CHECK: begin
        if (set_ok_c) begin
          load_c = 1'b1;
          ack_d  = 1'b1;
        end else begin
          err_d = 1'b1;
        end
      end
      default: ;
    endcase
  end

  assign term_c = advance_c && (presc_q == PRESC_TERM);

  always_comb begin
    presc_d = presc_q;
    if (load_c) begin
      presc_d = '0;
    end else if (advance_c) begin
      presc_d = term_c ? '0 : presc_q + PRESC_W'(1);
    end
  end

  // Hours pair wraps 23 -> 00 rather than per-digit limits
  assign day_wrap_c = min_tens_carry_c && ({hour_q.tens, hour_q.units} == MAX_HOUR);

  always_comb begin
    hour_d = hour_q;
    if (load_c) begin
      hour_d = bcd_pair_t'(set_hh);
    end else if (min_tens_carry_c) begin
      if (day_wrap_c) begin
        hour_d = '0;
      end else if (hour_q.units == MAX_UNITS) begin
        hour_d.tens  = hour_q.tens + DIGIT_W'(1);
        hour_d.units = '0;
      end else begin
        hour_d.units = hour_q.units + DIGIT_W'(1);
      end
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      presc_q    <= '0;
      hour_q     <= '0;
      set_ack_q  <= 1'b0;
      set_err_q  <= 1'b0;
      sec_tick_q <= 1'b0;
      day_tick_q <= 1'b0;
    end else begin
      presc_q    <= presc_d;
      hour_q     <= hour_d;
      set_ack_q  <= ack_d;
      set_err_q  <= err_d;
      sec_tick_q <= term_c;
      day_tick_q <= day_wrap_c;
    end
  end

  bcd_digit_counter #(.MAX(MAX_UNITS)) u_sec_units (
    .clk_i       (CLK),
    .rst_i       (RST),
    .inc_i       (term_c),
    .load_i      (1'b0),
    .load_val_i  (4'd0),
    .clr_i       (load_c),
    .digit_o     (sec_units),
    .carry_out_c (sec_units_carry_c)
  );

  bcd_digit_counter #(.MAX(MAX_TENS_MS)) u_sec_tens (
    .clk_i       (CLK),
    .rst_i       (RST),
    .inc_i       (sec_units_carry_c),
    .load_i      (1'b0),
    .load_val_i  (4'd0),
    .clr_i       (load_c),
    .digit_o     (sec_tens),
    .carry_out_c (sec_tens_carry_c)
  );

  bcd_digit_counter #(.MAX(MAX_UNITS)) u_min_units (
    .clk_i       (CLK),
    .rst_i       (RST),
    .inc_i       (sec_tens_carry_c),
    .load_i      (load_c),
    .load_val_i  (set_mm[3:0]),
    .clr_i       (1'b0),
    .digit_o     (min_units),
    .carry_out_c (min_units_carry_c)
  );

  bcd_digit_counter #(.MAX(MAX_TENS_MS)) u_min_tens (
    .clk_i       (CLK),
    .rst_i       (RST),
    .inc_i       (min_units_carry_c),
    .load_i      (load_c),
    .load_val_i  (set_mm[7:4]),
    .clr_i       (1'b0),
    .digit_o     (min_tens),
    .carry_out_c (min_tens_carry_c)
  );

  assign hour_tens    = hour_q.tens;
  assign hour_units   = hour_q.units;
  assign set_ack      = set_ack_q;
  assign set_err      = set_err_q;
  assign sec_tick     = sec_tick_q;
  assign day_tick     = day_tick_q;
  assign ny_countdown = ny_eve && ({hour_q.tens, hour_q.units} == MAX_HOUR)
                     && (min_tens == MAX_TENS_MS);

endmodule

// File: tb/tb_clock_time_counter.sv
// Randomized scoreboard bench for clock_time_counter against a seconds-of-day reference model.
module tb_clock_time_counter;

  localparam int TPS      = 4;
  localparam int DAY      = 86400;
  localparam int NY_START = 23 * 3600 + 50 * 60;

  logic       CLK = 1'b0;
  logic       RST;
  logic       run_en, ny_eve, set_valid;
  logic [7:0] set_hh, set_mm;
  logic       set_ack, set_err, sec_tick, day_tick, ny_countdown;
  logic [3:0] hour_tens, hour_units, min_tens, min_units, sec_tens, sec_units;

  clock_time_counter #(.TICKS_PER_SEC(TPS)) dut (
    .CLK(CLK), .RST(RST), .run_en(run_en), .ny_eve(ny_eve),
    .set_valid(set_valid), .set_hh(set_hh), .set_mm(set_mm),
    .set_ack(set_ack), .set_err(set_err),
    .hour_tens(hour_tens), .hour_units(hour_units),
    .min_tens(min_tens), .min_units(min_units),
    .sec_tens(sec_tens), .sec_units(sec_units),
    .sec_tick(sec_tick), .day_tick(day_tick), .ny_countdown(ny_countdown)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    bit tick;
    bit day;
    bit ack;
    bit err;
  } ev_t;

  ev_t sbq[$];
  int  total = 0;
  int  bad   = 0;
  int  n_tick = 0, n_day = 0, n_ack = 0, n_err = 0;

  // Reference model: time as seconds since midnight, handshake as a phase number.
  int m_secs  = 0;
  int m_presc = 0;
  int m_phase = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [23:0] exp_digits(input int s);
    int h, m, sc;
    h  = s / 3600;
    m  = (s / 60) % 60;
    sc = s % 60;
    return {4'(h / 10), 4'(h % 10), 4'(m / 10), 4'(m % 10), 4'(sc / 10), 4'(sc % 10)};
  endfunction

  function automatic bit req_ok(input logic [7:0] hh, input logic [7:0] mm);
    int ht, hu, mt, mu;
    ht = int'(hh[7:4]); hu = int'(hh[3:0]);
    mt = int'(mm[7:4]); mu = int'(mm[3:0]);
    if (ht > 9 || hu > 9 || mt > 9 || mu > 9) return 1'b0;
    return (ht * 10 + hu < 24) && (mt * 10 + mu < 60);
  endfunction

  function automatic logic [23:0] dut_digits();
    return {hour_tens, hour_units, min_tens, min_units, sec_tens, sec_units};
  endfunction

  task automatic push_ev(input bit tick, input bit day, input bit ack, input bit err);
    ev_t e;
    e.tick = tick; e.day = day; e.ack = ack; e.err = err;
    sbq.push_back(e);
  endtask

  initial begin : model
    forever begin
      @(posedge CLK or posedge RST);
      if (RST) begin
        m_secs = 0; m_presc = 0; m_phase = 0;
        sbq.delete();
      end else begin
        case (m_phase)
          0: begin
            if (set_valid) begin
              m_phase = 1;
            end else if (run_en) begin
              if (m_presc == TPS - 1) begin
                m_presc = 0;
                m_secs  = (m_secs + 1) % DAY;
                push_ev(1'b1, m_secs == 0, 1'b0, 1'b0);
              end else begin
                m_presc++;
              end
            end
          end
          1: begin
            if (req_ok(set_hh, set_mm)) begin
              m_secs  = (int'(set_hh[7:4]) * 10 + int'(set_hh[3:0])) * 3600
                      + (int'(set_mm[7:4]) * 10 + int'(set_mm[3:0])) * 60;
              m_presc = 0;
              push_ev(1'b0, 1'b0, 1'b1, 1'b0);
            end else begin
              push_ev(1'b0, 1'b0, 1'b0, 1'b1);
            end
            m_phase = 2;
          end
          default: if (!set_valid) m_phase = 0;
        endcase
      end
    end
  end

  initial begin : monitor
    ev_t e;
    forever begin
      @(negedge CLK);
      if (!RST) begin
        chk("digits", 32'(dut_digits()), 32'(exp_digits(m_secs)));
        chk("ny_countdown", 32'(ny_countdown), 32'(ny_eve && (m_secs >= NY_START)));
        if (sec_tick || set_ack || set_err) begin
          n_tick += int'(sec_tick); n_day += int'(day_tick);
          n_ack  += int'(set_ack);  n_err += int'(set_err);
          if (sbq.size() == 0) begin
            chk("unexpected_event", 32'({sec_tick, day_tick, set_ack, set_err}), 32'(0));
          end else begin
            e = sbq.pop_front();
            chk("event", 32'({sec_tick, day_tick, set_ack, set_err}),
                32'({e.tick, e.day, e.ack, e.err}));
          end
        end else begin
          chk("day_tick_idle", 32'(day_tick), 32'(0));
        end
      end
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge CLK);
      #1;
    end
  endtask

  // Raise a request, wait for ack/err, keep it high `hold` cycles with junk data, then release.
  task automatic do_set(input logic [7:0] hh, input logic [7:0] mm, input int hold);
    bit seen;
    seen = 1'b0;
    set_hh = hh; set_mm = mm; set_valid = 1'b1;
    for (int i = 0; i < 20 && !seen; i++) begin
      step(1);
      if (set_ack || set_err) seen = 1'b1;
    end
    if (!seen) chk("handshake_timeout", 32'(0), 32'(1));
    for (int i = 0; i < hold; i++) begin
      set_hh = 8'($urandom); set_mm = 8'($urandom);
      step(1);
    end
    set_valid = 1'b0;
    set_hh = 8'($urandom); set_mm = 8'($urandom);
    step(1);
  endtask

  function automatic logic [7:0] rand_valid_hh();
    int h;
    h = ($urandom_range(0, 1) == 1) ? 23 : int'($urandom_range(0, 23));
    return {4'(h / 10), 4'(h % 10)};
  endfunction

  function automatic logic [7:0] rand_valid_mm();
    int m;
    m = ($urandom_range(0, 1) == 1) ? 59 : int'($urandom_range(0, 59));
    return {4'(m / 10), 4'(m % 10)};
  endfunction

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    int a0, e0, d0;
    RST = 1'b1; run_en = 1'b0; ny_eve = 1'b0; set_valid = 1'b0;
    set_hh = 8'h00; set_mm = 8'h00;
    step(3);
    chk("reset_digits", 32'(dut_digits()), 32'(0));
    chk("reset_pulses", 32'({set_ack, set_err, sec_tick, day_tick, ny_countdown}), 32'(0));

    RST = 1'b0; run_en = 1'b1;
    repeat (40) @(posedge CLK);
    @(negedge CLK); #1;
    chk("run40_digits", 32'(dut_digits()), 32'(24'h000010));
    chk("run40_ticks", 32'(n_tick), 32'(10));
    chk("run40_no_day", 32'(n_day), 32'(0));
    step(1);

    a0 = n_ack; d0 = n_day;
    do_set(8'h23, 8'h59, 0);
    chk("set2359_ack", 32'(n_ack - a0), 32'(1));
    chk("set2359_digits", 32'(dut_digits()), 32'(24'h235900));
    repeat (240) @(posedge CLK);
    @(negedge CLK); #1;
    chk("midnight_digits", 32'(dut_digits()), 32'(0));
    chk("midnight_day_tick", 32'(n_day - d0), 32'(1));
    step(1);

    ny_eve = 1'b1;
    do_set(8'h23, 8'h49, 0);
    repeat (236) @(posedge CLK);
    @(negedge CLK); #1;
    chk("ny_234959", 32'({dut_digits(), 7'd0, ny_countdown}), 32'({24'h234959, 8'h00}));
    repeat (4) @(posedge CLK);
    @(negedge CLK); #1;
    chk("ny_235000", 32'({dut_digits(), 7'd0, ny_countdown}), 32'({24'h235000, 8'h01}));
    step(1);

    run_en = 1'b0;
    a0 = n_ack; e0 = n_err;
    do_set(8'h24, 8'h00, 0);
    do_set(8'h1A, 8'h10, 2);
    do_set(8'h12, 8'h60, 0);
    chk("invalid_errs", 32'(n_err - e0), 32'(3));
    chk("invalid_no_ack", 32'(n_ack - a0), 32'(0));
    chk("invalid_time_kept", 32'(dut_digits()), 32'(24'h235000));

    // Request on the prescaler terminal cycle: set wins, no increment.
    run_en = 1'b1; ny_eve = 1'b0;
    for (int i = 0; i < 10 && m_presc != TPS - 1; i++) step(1);
    a0 = n_ack;
    do_set(8'h07, 8'h30, 10);
    chk("tc_single_ack", 32'(n_ack - a0), 32'(1));
    chk("tc_loaded", 32'(dut_digits()), 32'(24'h073000));

    // Reset while the request is in CHECK, then let the handshake restart.
    set_hh = 8'h12; set_mm = 8'h34; set_valid = 1'b1;
    step(1);
    RST = 1'b1;
    #1;
    chk("rst_check_digits", 32'(dut_digits()), 32'(0));
    chk("rst_check_pulses", 32'({set_ack, set_err, sec_tick, day_tick}), 32'(0));
    step(1);
    RST = 1'b0;
    a0 = n_ack;
    do_set(8'h12, 8'h34, 1);
    chk("rst_restart_ack", 32'(n_ack - a0), 32'(1));

    for (int it = 0; it < 80; it++) begin
      run_en = ($urandom_range(0, 3) != 0);
      ny_eve = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 5))
        3: do_set(rand_valid_hh(), rand_valid_mm(), int'($urandom_range(0, 5)));
        4: do_set(8'($urandom), 8'($urandom), int'($urandom_range(0, 3)));
        5: begin
          set_hh = 8'($urandom); set_mm = 8'($urandom);
          set_valid = 1'($urandom_range(0, 1));
          step(int'($urandom_range(0, 2)));
          RST = 1'b1;
          step(1);
          RST = 1'b0; set_valid = 1'b0;
          step(1);
        end
        default: begin
          for (int k = 0; k < int'($urandom_range(1, 40)); k++) begin
            set_hh = 8'($urandom); set_mm = 8'($urandom);
            step(1);
          end
        end
      endcase
    end

    set_valid = 1'b0;
    step(5);
    chk("scoreboard_drained", 32'(sbq.size()), 32'(0));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
